// File: rtl/isr_shifter.sv
// Input shift register: shifts masked pin samples into a 32-bit ISR and hands
// completed words to the RX FIFO through explicit PUSH or autopush.
module isr_shifter (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pin_data,
    input  logic        in_valid,
    input  logic [4:0]  in_count,
    input  logic        push_req,
    input  logic        push_block,
    input  logic        cfg_shift_right,
    input  logic        cfg_autopush,
    input  logic [4:0]  cfg_thresh,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        stall,
    output logic [31:0] isr_value,
    output logic [5:0]  shift_count,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUSH_BLK = 2'd1,
        PUSH_NB  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_isr, w_isr_nxt;
    logic [5:0]  r_count, w_count_nxt;
    logic        r_overflow, w_overflow_nxt;

    logic [5:0]  w_n;
    logic [5:0]  w_thresh;
    logic [31:0] w_mask;
    logic [31:0] w_d;
    logic [31:0] w_shifted;
    logic [6:0]  w_sum;
    logic [5:0]  w_count_in;

    // A count field of zero means a full 32-bit transfer.
    assign w_n        = (in_count == 5'd0) ? 6'd32 : {1'b0, in_count};
    assign w_thresh   = (cfg_thresh == 5'd0) ? 6'd32 : {1'b0, cfg_thresh};
    assign w_mask     = (w_n == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << w_n) - 32'd1);
    assign w_d        = pin_data & w_mask;
    assign w_sum      = {1'b0, r_count} + {1'b0, w_n};
    assign w_count_in = (w_sum > 7'd32) ? 6'd32 : w_sum[5:0];

    always_comb begin
        w_shifted = w_d;
        if (w_n != 6'd32) begin
            if (cfg_shift_right)
                w_shifted = (r_isr >> w_n) | (w_d << (6'd32 - w_n));
            else
                w_shifted = (r_isr << w_n) | w_d;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_isr_nxt      = r_isr;
        w_count_nxt    = r_count;
        w_overflow_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_isr_nxt   = w_shifted;
                    w_count_nxt = w_count_in;
                    if (cfg_autopush && (w_count_in >= w_thresh))
                        w_state_nxt = PUSH_BLK;
                end else if (push_req) begin
                    w_state_nxt = push_block ? PUSH_BLK : PUSH_NB;
                end
            end
            PUSH_BLK: begin
                if (rx_ready) begin
                    w_isr_nxt   = '0;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            PUSH_NB: begin
                // Word is dropped if the FIFO is full; flag it next cycle.
                w_isr_nxt      = '0;
                w_count_nxt    = '0;
                w_state_nxt    = IDLE;
                w_overflow_nxt = ~rx_ready;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_isr      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_isr      <= w_isr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign stall       = (r_state != IDLE);
    assign rx_valid    = stall;
    assign rx_data     = stall ? r_isr : 32'd0;
    assign isr_value   = r_isr;
    assign shift_count = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_isr_shifter.sv
// Directed bench for isr_shifter: shift directions, masking, saturation,
// autopush, blocking/non-blocking push, priority and reset abandonment.
module tb_isr_shifter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pin_data;
    logic        in_valid;
    logic [4:0]  in_count;
    logic        push_req;
    logic        push_block;
    logic        cfg_shift_right;
    logic        cfg_autopush;
    logic [4:0]  cfg_thresh;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        stall;
    logic [31:0] isr_value;
    logic [5:0]  shift_count;
    logic        overflow;

    int n_total = 0;
    int n_bad   = 0;

    isr_shifter dut (
        .clock           (clock),
        .reset           (reset),
        .pin_data        (pin_data),
        .in_valid        (in_valid),
        .in_count        (in_count),
        .push_req        (push_req),
        .push_block      (push_block),
        .cfg_shift_right (cfg_shift_right),
        .cfg_autopush    (cfg_autopush),
        .cfg_thresh      (cfg_thresh),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .stall           (stall),
        .isr_value       (isr_value),
        .shift_count     (shift_count),
        .overflow        (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_in(input logic [4:0] n, input logic [31:0] pins);
        in_valid = 1'b1;
        in_count = n;
        pin_data = pins;
        tick();
        in_valid = 1'b0;
        pin_data = 32'd0;
    endtask

    task automatic do_push(input logic blk);
        push_req   = 1'b1;
        push_block = blk;
        tick();
        push_req   = 1'b0;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_isr"},   isr_value,   32'd0);
        chk({tag, "_cnt"},   32'(shift_count), 32'd0);
        chk({tag, "_vld"},   32'(rx_valid), 32'd0);
        chk({tag, "_stall"}, 32'(stall),    32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
        chk({tag, "_data"},  rx_data,     32'd0);
    endtask

    initial begin
        reset = 1'b1; pin_data = 0; in_valid = 0; in_count = 0;
        push_req = 0; push_block = 0; cfg_shift_right = 0;
        cfg_autopush = 0; cfg_thresh = 0; rx_ready = 1;
        tick(); tick();
        chk_idle_reset("reset");
        reset = 1'b0;
        tick();

        // left shift and masking
        do_in(5'd4, 32'hA);
        do_in(5'd4, 32'h5);
        chk("left_isr", isr_value, 32'h0000_00A5);
        chk("left_cnt", 32'(shift_count), 32'd8);
        do_in(5'd3, 32'hFFFF_FFFF);
        chk("mask_isr", isr_value, 32'h0000_052F);
        chk("mask_cnt", 32'(shift_count), 32'd11);

        // blocking explicit push, FIFO ready
        rx_ready = 1'b1;
        do_push(1'b1);
        chk("pblk_vld",   32'(rx_valid), 32'd1);
        chk("pblk_stall", 32'(stall),    32'd1);
        chk("pblk_data",  rx_data,       32'h0000_052F);
        tick();
        chk("pblk_done_stall", 32'(stall), 32'd0);
        chk("pblk_done_isr",   isr_value,  32'd0);
        chk("pblk_done_cnt",   32'(shift_count), 32'd0);

        // right shift, n=32 and saturation
        cfg_shift_right = 1'b1;
        do_in(5'd8, 32'h0000_FF12);
        chk("right_isr", isr_value, 32'h1200_0000);
        do_in(5'd0, 32'hDEAD_BEEF);
        chk("right32_isr", isr_value, 32'hDEAD_BEEF);
        chk("right32_cnt", 32'(shift_count), 32'd32);
        do_push(1'b0);
        tick();
        chk("clr_isr", isr_value, 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // autopush: below threshold, then at threshold with FIFO stalled
        cfg_shift_right = 1'b0;
        cfg_autopush    = 1'b1;
        cfg_thresh      = 5'd8;
        do_in(5'd4, 32'h3);
        chk("ap_below_stall", 32'(stall), 32'd0);
        do_in(5'd4, 32'hC);
        chk("ap_hit_stall", 32'(stall), 32'd1);
        tick();
        chk("ap2_clr", isr_value, 32'd0);
        rx_ready = 1'b0;
        do_in(5'd8, 32'h3C);
        in_valid = 1'b1; in_count = 5'd8; pin_data = 32'hFF;
        cfg_shift_right = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("ap_wait_vld",   32'(rx_valid), 32'd1);
            chk("ap_wait_stall", 32'(stall),    32'd1);
            chk("ap_wait_data",  rx_data,       32'h0000_003C);
            tick();
        end
        rx_ready = 1'b1;
        chk("ap_c4_vld",  32'(rx_valid), 32'd1);
        chk("ap_c4_data", rx_data,       32'h0000_003C);
        in_valid = 1'b0; pin_data = 32'd0;
        tick();
        chk("ap_done_vld", 32'(rx_valid), 32'd0);
        chk("ap_done_isr", isr_value,     32'd0);
        chk("ap_done_cnt", 32'(shift_count), 32'd0);
        cfg_shift_right = 1'b0;
        cfg_autopush    = 1'b0;

        // non-blocking push dropped on full FIFO
        do_in(5'd8, 32'h55);
        rx_ready = 1'b0;
        do_push(1'b0);
        chk("nb_vld",  32'(rx_valid), 32'd1);
        chk("nb_data", rx_data,       32'h0000_0055);
        chk("nb_ovf0", 32'(overflow), 32'd0);
        tick();
        chk("nb_after_vld", 32'(rx_valid), 32'd0);
        chk("nb_after_isr", isr_value,     32'd0);
        chk("nb_ovf1",      32'(overflow), 32'd1);
        tick();
        chk("nb_ovf2", 32'(overflow), 32'd0);

        // non-blocking push accepted
        rx_ready = 1'b1;
        do_in(5'd8, 32'h55);
        do_push(1'b0);
        chk("nbok_data", rx_data, 32'h0000_0055);
        tick();
        chk("nbok_ovf", 32'(overflow), 32'd0);
        chk("nbok_isr", isr_value,     32'd0);

        // in_valid wins over push_req
        in_valid = 1'b1; in_count = 5'd4; pin_data = 32'h9;
        push_req = 1'b1; push_block = 1'b1;
        tick();
        in_valid = 1'b0; push_req = 1'b0;
        chk("prio_isr",   isr_value,  32'h0000_0009);
        chk("prio_stall", 32'(stall), 32'd0);

        // empty push is allowed after clearing
        do_push(1'b1);
        tick();
        do_push(1'b1);
        chk("empty_vld",  32'(rx_valid), 32'd1);
        chk("empty_data", rx_data,       32'd0);
        tick();

        // reset during PUSH_BLK
        do_in(5'd4, 32'h7);
        rx_ready = 1'b0;
        do_push(1'b1);
        chk("rstblk_pre_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_reset("rstblk");

        // reset during PUSH_NB with full FIFO: no overflow
        do_in(5'd4, 32'h7);
        do_push(1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_reset("rstnb");
        tick();
        chk("rstnb_ovf_next", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
